mac_dot_seq: RTL and testbench

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

---
 rtl/mac_dot_seq.sv | 149 ++++++++++++++
 tb/tb_mac_dot_seq.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// Sequential signed dot-product engine: LEN beats of w*x are accumulated and the
// shifted, saturated or wrapped sum is held on a valid/ready output until taken.
module mac_dot_seq #(
    parameter int WIDTH     = 8,
    parameter int LEN       = 4,
    parameter int OUT_WIDTH = 2 * WIDTH,
    parameter int SHIFT     = 0,
    parameter int SAT       = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     w,
    input  logic signed [WIDTH-1:0]     x,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] out,
    output logic                        ovf
);

    localparam int PROD_W = 2 * WIDTH;
    localparam int CNT_W  = $clog2(LEN);
    localparam int ACC_W  = PROD_W + CNT_W;
    localparam int EXT_W  = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;

    typedef enum logic [1:0] {ACCUM, DRAIN, HOLD} state_t;

    state_t state, state_nxt;

    logic                     accept;
    logic                     abort;
    logic                     is_last;
    logic [CNT_W-1:0]         cnt;

    logic signed [PROD_W-1:0] prod_p1;
    logic                     vld_p1;
    logic                     first_p1;
    logic                     last_p1;

    logic signed [ACC_W-1:0]  acc_p2;
    logic                     vld_p2;
    logic                     last_p2;
    logic                     fin_p2;

    function automatic logic signed [EXT_W-1:0] shift_ext(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> SHIFT;
        return EXT_W'(sh);
    endfunction

    // Returns {ovf, value}; the widened operand lets the range test see every bit.
    function automatic logic [OUT_WIDTH:0] limit(input logic signed [EXT_W-1:0] v);
        logic signed [EXT_W-1:0] omax;
        logic signed [EXT_W-1:0] omin;
        logic [OUT_WIDTH:0]      res;
        omax = {{(EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
        omin = ~omax;
        if (v > omax) begin
            res = {1'b1, (SAT != 0) ? omax[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0]};
        end else if (v < omin) begin
            res = {1'b1, (SAT != 0) ? omin[OUT_WIDTH-1:0] : v[OUT_WIDTH-1:0]};
        end else begin
            res = {1'b0, v[OUT_WIDTH-1:0]};
        end
        return res;
    endfunction

    assign abort   = clear && (state != HOLD);
    assign accept  = in_valid && in_ready && !clear;
    assign is_last = (cnt == CNT_W'(LEN - 1));
    assign fin_p2  = vld_p2 && last_p2;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (accept && is_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (clear)       state_nxt = ACCUM;
                else if (fin_p2) state_nxt = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = ACCUM;
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else     state <= state_nxt;
    end

    // Stage 0 -> 1: beat counter, control flags and registered product
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            cnt      <= '0;
            vld_p1   <= 1'b0;
            first_p1 <= 1'b0;
            last_p1  <= 1'b0;
        end else begin
            if (accept) cnt <= is_last ? '0 : cnt + 1'b1;
            vld_p1   <= accept;
            first_p1 <= (cnt == '0);
            last_p1  <= is_last;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) prod_p1 <= PROD_W'(w) * PROD_W'(x);
    end

    // Stage 1 -> 2: the first product of a vector loads the accumulator
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_p2 <= '0;
        end else if (vld_p1 && !abort) begin
            acc_p2 <= first_p1 ? ACC_W'(prod_p1) : acc_p2 + ACC_W'(prod_p1);
        end
    end

    // Stage 2 -> output: result is captured once and held through HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            out <= '0;
            ovf <= 1'b0;
        end else if (fin_p2 && !abort) begin
            {ovf, out} <= limit(shift_ext(acc_p2));
        end
    end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Directed and randomized bench for mac_dot_seq; three instances share stimulus
// (defaults, SAT=0, SHIFT=1) and are checked against an arithmetic reference.
module tb_mac_dot_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, clear, in_valid, out_ready;
    logic signed [7:0] w, x;

    logic               rdy0, rdy1, rdy2;
    logic               ov0, ov1, ov2;
    logic signed [15:0] o0, o1, o2;
    logic               f0, f1, f2;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mac_dot_seq #(.WIDTH(8), .LEN(4), .OUT_WIDTH(16), .SHIFT(0), .SAT(1)) d0 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy0),
        .w(w), .x(x), .out_valid(ov0), .out_ready(out_ready), .out(o0), .ovf(f0));

    mac_dot_seq #(.WIDTH(8), .LEN(4), .OUT_WIDTH(16), .SHIFT(0), .SAT(0)) d1 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy1),
        .w(w), .x(x), .out_valid(ov1), .out_ready(out_ready), .out(o1), .ovf(f1));

    mac_dot_seq #(.WIDTH(8), .LEN(4), .OUT_WIDTH(16), .SHIFT(1), .SAT(1)) d2 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(rdy2),
        .w(w), .x(x), .out_valid(ov2), .out_ready(out_ready), .out(o2), .ovf(f2));

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference: plain dot product, arithmetic shift, then clamp or wrap to 16 bits.
    task automatic model(input int wv[4], input int xv[4], input int sh, input bit sat,
                         output longint o, output longint ov);
        longint     s;
        logic [15:0] lo;
        s = 0;
        for (int i = 0; i < 4; i++) s += longint'(wv[i]) * longint'(xv[i]);
        s = s >>> sh;
        ov = 0;
        o  = s;
        if (s > 32767 || s < -32768) begin
            ov = 1;
            lo = s[15:0];
            if (sat) o = (s > 0) ? 32767 : -32768;
            else     o = {{48{lo[15]}}, lo};
        end
    endtask

    task automatic send_vec(input int wv[4], input int xv[4], input bit gaps, output int last_cyc);
        last_cyc = cyc;
        for (int i = 0; i < 4; i++) begin
            if (gaps) begin
                int g;
                g = $urandom_range(0, 2);
                repeat (g) begin
                    in_valid = 1'b0;
                    w = 8'($urandom);
                    x = 8'($urandom);
                    tick();
                end
            end
            in_valid = 1'b1;
            w = 8'(wv[i]);
            x = 8'(xv[i]);
            for (int k = 0; k < 50 && !rdy0; k++) tick();
            if (!rdy0) chk("in_ready_timeout", 0, 1);
            tick();
            last_cyc = cyc;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int last_cyc, input string tag);
        for (int k = 0; k < 30 && !ov0; k++) tick();
        chk({tag, "_latency"}, longint'(cyc - last_cyc), 2);
    endtask

    task automatic check_res(input int wv[4], input int xv[4], input string tag);
        longint e, eo;
        chk({tag, "_vld0"}, longint'(ov0), 1);
        model(wv, xv, 0, 1'b1, e, eo);
        chk({tag, "_out0"}, longint'(o0), e);
        chk({tag, "_ovf0"}, longint'(f0), eo);
        chk({tag, "_vld1"}, longint'(ov1), 1);
        model(wv, xv, 0, 1'b0, e, eo);
        chk({tag, "_out1"}, longint'(o1), e);
        chk({tag, "_ovf1"}, longint'(f1), eo);
        chk({tag, "_vld2"}, longint'(ov2), 1);
        model(wv, xv, 1, 1'b1, e, eo);
        chk({tag, "_out2"}, longint'(o2), e);
        chk({tag, "_ovf2"}, longint'(f2), eo);
    endtask

    task automatic handshake(input string tag);
        chk({tag, "_rdy_hold"}, longint'(rdy0), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_after"}, longint'(ov0), 0);
        chk({tag, "_rdy_after"}, longint'(rdy0), 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int wv[4], xv[4];
        int lc;
        longint held;

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; w = '0; x = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", longint'(ov0), 0);
        chk("rst_out", longint'(o0), 0);
        chk("rst_ovf", longint'(f0), 0);
        chk("rst_in_ready", longint'(rdy0), 1);

        // back-to-back beats
        wv = '{1, 3, 5, 7}; xv = '{2, 4, 6, 8};
        send_vec(wv, xv, 1'b0, lc);
        chk("b2b_early_vld", longint'(ov0), 0);
        wait_out(lc, "b2b");
        chk("b2b_out_const", longint'(o0), 100);
        chk("b2b_ovf_const", longint'(f0), 0);
        check_res(wv, xv, "b2b");
        handshake("b2b");

        // saturate vs wrap
        wv = '{-128, -128, -128, -128}; xv = '{-128, -128, -128, -128};
        send_vec(wv, xv, 1'b0, lc);
        wait_out(lc, "ext");
        chk("ext_sat_out", longint'(o0), 32767);
        chk("ext_sat_ovf", longint'(f0), 1);
        chk("ext_wrap_out", longint'(o1), 0);
        chk("ext_wrap_ovf", longint'(f1), 1);
        check_res(wv, xv, "ext");
        handshake("ext");

        // gaps plus backpressure; clear and stray beats during HOLD must be ignored
        wv = '{1, 3, 5, 7}; xv = '{2, 4, 6, 8};
        send_vec(wv, xv, 1'b1, lc);
        wait_out(lc, "bp");
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; w = 8'($urandom); x = 8'($urandom);
            clear = (i == 2);
            tick();
            chk("bp_hold_vld", longint'(ov0), 1);
            chk("bp_hold_out", longint'(o0), 100);
            chk("bp_hold_ovf", longint'(f0), 0);
            chk("bp_hold_rdy", longint'(rdy0), 0);
        end
        in_valid = 1'b0; clear = 1'b0;
        handshake("bp");

        // abort in ACCUM: two beats, clear with a beat present, then a fresh vector
        in_valid = 1'b1; w = 8'sd10; x = 8'sd10;
        tick();
        tick();
        clear = 1'b1; w = 8'sd50; x = 8'sd50;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("clr_no_vld", longint'(ov0), 0);
        end
        wv = '{1, 1, 1, 1}; xv = '{1, 1, 1, 1};
        send_vec(wv, xv, 1'b0, lc);
        wait_out(lc, "clr");
        chk("clr_out_const", longint'(o0), 4);
        check_res(wv, xv, "clr");
        handshake("clr");

        // abort in DRAIN: the pending sum must never appear
        wv = '{9, 9, 9, 9}; xv = '{9, 9, 9, 9};
        send_vec(wv, xv, 1'b0, lc);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_clr_no_vld", longint'(ov0), 0);
            tick();
        end
        chk("drain_clr_rdy", longint'(rdy0), 1);

        // reset while a result is pending
        wv = '{1, 3, 5, 7}; xv = '{2, 4, 6, 8};
        send_vec(wv, xv, 1'b0, lc);
        wait_out(lc, "rsth");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rsth_vld", longint'(ov0), 0);
        chk("rsth_out", longint'(o0), 0);
        chk("rsth_rdy", longint'(rdy0), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rsth_no_vld", longint'(ov0), 0);
        end
        wv = '{-3, -3, -3, -3}; xv = '{5, 5, 5, 5};
        send_vec(wv, xv, 1'b0, lc);
        wait_out(lc, "neg");
        chk("neg_out_const", longint'(o0), -60);
        check_res(wv, xv, "neg");
        handshake("neg");

        // arithmetic shift truncation
        wv = '{3, 0, 0, 0}; xv = '{1, 0, 0, 0};
        send_vec(wv, xv, 1'b0, lc);
        wait_out(lc, "shf");
        chk("shf_out_const", longint'(o2), 1);
        chk("shf_ovf_const", longint'(f2), 0);
        check_res(wv, xv, "shf");
        handshake("shf");

        // randomized vectors with gaps and random consumer delay
        for (int n = 0; n < 12; n++) begin
            int dly;
            for (int i = 0; i < 4; i++) begin
                logic signed [7:0] tw, tx;
                tw = 8'($urandom);
                tx = 8'($urandom);
                if (n < 3) begin
                    tw = (n == 1) ? 8'sd127 : -8'sd128;
                    tx = (n == 2) ? 8'sd127 : -8'sd128;
                end
                wv[i] = int'(tw);
                xv[i] = int'(tx);
            end
            send_vec(wv, xv, 1'($urandom), lc);
            wait_out(lc, "rnd");
            held = longint'(o0);
            dly = $urandom_range(0, 3);
            for (int i = 0; i < dly; i++) begin
                tick();
                chk("rnd_hold_out", longint'(o0), held);
            end
            check_res(wv, xv, "rnd");
            handshake("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
